// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared FSM encoding, channel count and FIFO word layout for the ADC capture sequencer
package adc_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_FLUSH} state_t;
    localparam int CH_NUM  = 4;
    localparam int CH_W    = $clog2(CH_NUM);
    localparam int WORD_W  = 16;
    localparam int CH_LSB  = 14;
    localparam int SMP_LSB = 0;
    localparam int SMP_W   = 14;
    function automatic logic [CH_W-1:0] lsb_idx(input logic [CH_NUM-1:0] m);
        lsb_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (m[i]) lsb_idx = CH_W'(i);
    endfunction
endpackage

// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if: deserialized frame input and FIFO word output of the sequencer
interface adc_capture_sequencer_if #(parameter int DATA_WIDTH = 14);
    logic                      SAMPLE_VALID;
    logic [4*DATA_WIDTH-1:0]   SAMPLE_DATA;
    logic                      FIFO_READY;
    logic                      FIFO_VALID;
    logic [15:0]               FIFO_DATA;
    modport master (output SAMPLE_VALID, SAMPLE_DATA, FIFO_READY, input FIFO_VALID, FIFO_DATA);
    modport slave (input SAMPLE_VALID, SAMPLE_DATA, FIFO_READY, output FIFO_VALID, FIFO_DATA);
endinterface

// File: rtl/adc_seq_emitter.sv
// adc_seq_emitter: holds one frame and streams its enabled channels lowest-first under valid/ready
module adc_seq_emitter
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic [CH_NUM-1:0]            ch_en_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0] data_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [WORD_W-1:0]            word_o,
    output logic                         idle_o
);
    logic [CH_NUM*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [CH_NUM-1:0]            pend_q, pend_d;
    logic [CH_W-1:0]              sel;

    assign sel     = lsb_idx(pend_q);
    assign valid_o = |pend_q;
    assign idle_o  = ~valid_o;

    always_comb begin
        hold_d = load_i ? data_i : hold_q;
        pend_d = clear_i ? '0
               : load_i ? ch_en_i
               : (valid_o && ready_i) ? pend_q & ~(CH_NUM'(1) << sel)
               : pend_q;
        word_o = '0;
        if (valid_o) begin
            word_o[CH_LSB +: CH_W]        = sel;
            word_o[SMP_LSB +: DATA_WIDTH] = hold_q[sel*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            pend_q <= '0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: arm/trigger/skip/capture sequencing of ADC frames into a 16-bit FIFO word stream
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int CNT_WIDTH  = 16,
    parameter int LOST_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  TRIGGER,
    input  logic                  CONF_TRIG_EN,
    input  logic [CH_NUM-1:0]     CONF_CH_EN,
    input  logic [CNT_WIDTH-1:0]  CONF_DELAY,
    input  logic [CNT_WIDTH-1:0]  CONF_SAMPLES,
    adc_capture_sequencer_if.slave bus,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [LOST_WIDTH-1:0] LOST_COUNT
);
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_WIDTH-1:0]  delay_q, delay_d, samples_q, samples_d;
    logic [CH_NUM-1:0]     ch_en_q, ch_en_d;
    logic [LOST_WIDTH-1:0] lost_q, lost_d;
    logic                  trig_en_q, trig_en_d, trig_q, done_q, done_d;
    logic                  load, emit_idle;

    assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
    assign BUSY       = state_q != S_IDLE;
    assign DONE       = done_q;
    assign LOST_COUNT = lost_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_d   = delay_q;
        samples_d = samples_q;
        ch_en_d   = ch_en_q;
        trig_en_d = trig_en_q;
        lost_d    = lost_q;
        done_d    = 1'b0;
        load      = 1'b0;
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (START) begin
                    state_d   = CONF_TRIG_EN ? S_ARMED : S_DELAY;
                    cnt_d     = '0;
                    delay_d   = CONF_DELAY;
                    samples_d = CONF_SAMPLES;
                    ch_en_d   = CONF_CH_EN;
                    trig_en_d = CONF_TRIG_EN;
                    lost_d    = '0;
                end
                S_ARMED: if (TRIGGER && !trig_q) state_d = S_DELAY;
                S_DELAY: begin
                    if (cnt_q == delay_q) begin
                        state_d = S_CAPTURE;
                        cnt_d   = '0;
                    end else if (bus.SAMPLE_VALID) begin
                        cnt_d = cnt_inc;
                    end
                end
                S_CAPTURE: if (bus.SAMPLE_VALID) begin
                    if (emit_idle) begin
                        load  = 1'b1;
                        cnt_d = cnt_inc;
                        // samples==0 is continuous; guard so a counter wrap never matches it
                        if (samples_q != '0 && cnt_inc == samples_q) state_d = S_FLUSH;
                    end else begin
                        lost_d = (&lost_q) ? lost_q : lost_q + LOST_WIDTH'(1);
                    end
                end
                S_FLUSH: if (emit_idle) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            delay_q   <= '0;
            samples_q <= '0;
            ch_en_q   <= '0;
            trig_en_q <= 1'b0;
            lost_q    <= '0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            samples_q <= samples_d;
            ch_en_q   <= ch_en_d;
            trig_en_q <= trig_en_d;
            lost_q    <= lost_d;
            trig_q    <= TRIGGER;
            done_q    <= done_d;
        end
    end

    adc_seq_emitter #(.DATA_WIDTH(DATA_WIDTH)) u_emitter (
        .clk     (CLK),
        .rst     (RST),
        .clear_i (ABORT),
        .load_i  (load),
        .ch_en_i (ch_en_q),
        .data_i  (bus.SAMPLE_DATA),
        .ready_i (bus.FIFO_READY),
        .valid_o (bus.FIFO_VALID),
        .word_o  (bus.FIFO_DATA),
        .idle_o  (emit_idle)
    );
endmodule
